// File: rtl/datapath_controller_if.sv
// datapath_controller_if: control/status bundle between the multi-cycle
// controller (master) and the RV32 subset datapath (slave).
// Optional macro CTRL_PERF_CNT_EN adds the cycle_cnt/stall_cnt counters.
interface datapath_controller_if #(
    parameter int unsigned RETIRE_W = 16
);
    logic [31:0]         Instr;
    logic [3:0]          Status;
    logic                run;
    logic                mem_ready;
    logic [1:0]          imm_sel;
    logic                RegRW;
    logic                ALUsrc;
    logic [3:0]          ALUop;
    logic                MRW;
    logic                WB;
    logic                PCsrc;
    logic                pc_en;
    logic                halted;
    logic                illegal;
    logic [RETIRE_W-1:0] retired;
`ifdef CTRL_PERF_CNT_EN
    logic [RETIRE_W-1:0] cycle_cnt;
    logic [RETIRE_W-1:0] stall_cnt;
`endif

    modport master (
        input  Instr, Status, run, mem_ready,
`ifdef CTRL_PERF_CNT_EN
        output cycle_cnt, stall_cnt,
`endif
        output imm_sel, RegRW, ALUsrc, ALUop, MRW, WB, PCsrc, pc_en,
        output halted, illegal, retired
    );

    modport slave (
        output Instr, Status, run, mem_ready,
`ifdef CTRL_PERF_CNT_EN
        input  cycle_cnt, stall_cnt,
`endif
        input  imm_sel, RegRW, ALUsrc, ALUop, MRW, WB, PCsrc, pc_en,
        input  halted, illegal, retired
    );
endinterface

// File: rtl/datapath_controller.sv
// datapath_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WBACK/HALT sequencer
// for the RV32 subset datapath. Control outputs are decoded from the state
// register and the latched instruction fields; branches resolve on Status.
// Optional macro CTRL_PERF_CNT_EN adds cycle and stall counters.
module datapath_controller #(
    parameter int unsigned RETIRE_W        = 16,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    datapath_controller_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WBACK, HALT} state_t;
    typedef enum logic [2:0] {
        CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_SYSTEM, CL_ILLEGAL
    } class_t;

    state_t              state_q, state_d;
    logic [6:0]          op_q;
    logic [2:0]          f3_q;
    logic                b30_q;
    logic                illegal_q;
    logic [RETIRE_W-1:0] retired_q;

    class_t              cls;
    logic [1:0]          d_imm;
    logic                d_src;
    logic [3:0]          d_aluop;
    logic                d_wb;
    logic                taken;

    logic [1:0]          imm_sel;
    logic                reg_rw;
    logic                alu_src;
    logic [3:0]          alu_op;
    logic                mrw;
    logic                wb;
    logic                pc_src;
    logic                pc_en;

    // Instruction fields the controller never inspects (registers, immediates)
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

    // Classify the latched instruction and derive its datapath controls
    always_comb begin
        cls     = CL_ILLEGAL;
        d_imm   = 2'b00;
        d_src   = 1'b0;
        d_aluop = 4'b0100;
        d_wb    = 1'b1;
        taken   = 1'b0;
        case (op_q)
            7'b0110011, 7'b0010011: begin
                cls   = op_q[5] ? CL_OP : CL_OPIMM;
                d_src = ~op_q[5];
                case (f3_q)
                    3'b000:  d_aluop = (op_q[5] && b30_q) ? 4'b1100 : 4'b0100;
                    3'b100:  d_aluop = 4'b0010;
                    3'b110:  d_aluop = 4'b0001;
                    3'b111:  d_aluop = 4'b0000;
                    default: cls = CL_ILLEGAL;
                endcase
            end
            7'b0000011: begin
                if (f3_q == 3'b010) begin
                    cls   = CL_LOAD;
                    d_src = 1'b1;
                    d_wb  = 1'b0;
                end
            end
            7'b0100011: begin
                if (f3_q == 3'b010) begin
                    cls   = CL_STORE;
                    d_src = 1'b1;
                    d_imm = 2'b01;
                end
            end
            7'b1100011: begin
                cls     = CL_BRANCH;
                d_imm   = 2'b10;
                d_aluop = 4'b1100;
                case (f3_q)
                    3'b000:  taken = bus.Status[2];
                    3'b001:  taken = ~bus.Status[2];
                    3'b100:  taken = bus.Status[3] ^ bus.Status[0];
                    3'b101:  taken = ~(bus.Status[3] ^ bus.Status[0]);
                    3'b110:  taken = ~bus.Status[1];
                    3'b111:  taken = bus.Status[1];
                    default: cls = CL_ILLEGAL;
                endcase
            end
            7'b1110011: cls = CL_SYSTEM;
            default:    cls = CL_ILLEGAL;
        endcase
    end

    // Next-state selection and per-state control outputs
    always_comb begin
        state_d = state_q;
        imm_sel = 2'b00;
        reg_rw  = 1'b0;
        alu_src = 1'b0;
        alu_op  = 4'b0100;
        mrw     = 1'b0;
        wb      = 1'b1;
        pc_src  = 1'b0;
        pc_en   = 1'b0;
        if ((state_q inside {DECODE, EXEC, MEM, WBACK}) && cls != CL_ILLEGAL) begin
            imm_sel = d_imm;
            alu_src = d_src;
            alu_op  = d_aluop;
            wb      = d_wb;
        end
        case (state_q)
            FETCH: if (bus.run) state_d = DECODE;
            DECODE: begin
                if (cls == CL_SYSTEM)
                    state_d = HALT;
                else if (cls == CL_ILLEGAL)
                    state_d = HALT_ON_ILLEGAL ? HALT : WBACK;
                else
                    state_d = EXEC;
            end
            EXEC: begin
                case (cls)
                    CL_BRANCH: begin
                        pc_en   = 1'b1;
                        pc_src  = taken;
                        state_d = FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = MEM;
                    default:           state_d = WBACK;
                endcase
            end
            MEM: begin
                mrw = (cls == CL_STORE);
                if (bus.mem_ready) begin
                    if (cls == CL_STORE) begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WBACK;
                    end
                end
            end
            // An illegal instruction retires here as a NOP: no register write
            WBACK: begin
                reg_rw  = (cls != CL_ILLEGAL);
                pc_en   = 1'b1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    // State, latched instruction fields, sticky illegal flag, retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            op_q      <= '0;
            f3_q      <= '0;
            b30_q     <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && bus.run) begin
                op_q  <= bus.Instr[6:0];
                f3_q  <= bus.Instr[14:12];
                b30_q <= bus.Instr[30];
            end
            if (state_q == DECODE && cls == CL_ILLEGAL) illegal_q <= 1'b1;
            if (pc_en) retired_q <= retired_q + RETIRE_W'(1);
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [RETIRE_W-1:0] cycle_q;
    logic [RETIRE_W-1:0] stall_q;

    // Count live cycles and cycles spent waiting on run or mem_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            stall_q <= '0;
        end else begin
            if (state_q != HALT) cycle_q <= cycle_q + RETIRE_W'(1);
            if ((state_q == FETCH && !bus.run) || (state_q == MEM && !bus.mem_ready))
                stall_q <= stall_q + RETIRE_W'(1);
        end
    end

    assign bus.cycle_cnt = cycle_q;
    assign bus.stall_cnt = stall_q;
`endif

    assign bus.imm_sel = imm_sel;
    assign bus.RegRW   = reg_rw;
    assign bus.ALUsrc  = alu_src;
    assign bus.ALUop   = alu_op;
    assign bus.MRW     = mrw;
    assign bus.WB      = wb;
    assign bus.PCsrc   = pc_src;
    assign bus.pc_en   = pc_en;
    assign bus.halted  = (state_q == HALT);
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_datapath_controller.sv
// tb_datapath_controller: randomized bench for datapath_controller. A
// per-instruction reference model expands each instruction into its
// expected cycle-by-cycle control trace from the class/latency rules.
module tb_datapath_controller;
    localparam int unsigned RW = 4;   // small counter so wrap is reachable

    localparam int K_R   = 0;
    localparam int K_I   = 1;
    localparam int K_LD  = 2;
    localparam int K_ST  = 3;
    localparam int K_BR  = 4;
    localparam int K_SYS = 5;
    localparam int K_ILL = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    datapath_controller_if #(.RETIRE_W(RW)) bus ();
    datapath_controller #(.RETIRE_W(RW), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // exp layout: {imm_sel[1:0], RegRW, ALUsrc, ALUop[3:0], MRW, WB, PCsrc, pc_en, halted, illegal}
    typedef struct {
        logic        run;
        logic        mem_ready;
        logic [3:0]  status;
        logic [31:0] instr;
        logic [13:0] exp;
    } cyc_t;

    cyc_t          trace[$];
    int            tests = 0;
    int            fails = 0;
    logic [RW-1:0] m_retired;
    logic          m_illegal;

    function automatic logic [13:0] mk(logic [1:0] imm, logic rw, logic src, logic [3:0] aop,
                                       logic mrw, logic wb, logic pcs, logic pe,
                                       logic hlt, logic ill);
        return {imm, rw, src, aop, mrw, wb, pcs, pe, hlt, ill};
    endfunction

    function automatic logic [13:0] idle(logic hlt, logic ill);
        return mk(2'b00, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, hlt, ill);
    endfunction

    function automatic logic [13:0] obs();
        return {bus.imm_sel, bus.RegRW, bus.ALUsrc, bus.ALUop, bus.MRW, bus.WB,
                bus.PCsrc, bus.pc_en, bus.halted, bus.illegal};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void add(logic run, logic mr, logic [3:0] st, logic [31:0] ins,
                                logic [13:0] e);
        cyc_t c;
        c.run = run; c.mem_ready = mr; c.status = st; c.instr = ins; c.exp = e;
        trace.push_back(c);
    endfunction

    function automatic logic [3:0] alu_of(logic [2:0] f3, logic sub);
        case (f3)
            3'b000:  return sub ? 4'b1100 : 4'b0100;
            3'b100:  return 4'b0010;
            3'b110:  return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic br_taken(logic [2:0] f3, logic [3:0] st);
        logic n, z, c, v;
        n = st[3]; z = st[2]; c = st[1]; v = st[0];
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return n ^ v;
            3'b101:  return !(n ^ v);
            3'b110:  return !c;
            default: return c;
        endcase
    endfunction

    // Expand one instruction into the expected trace of controller cycles.
    function automatic void build_trace(input logic [31:0] in, input int waits, input int stalls,
                                        input int halt_tail, input bit st_rand,
                                        input logic [3:0] st_fix);
        logic [6:0] op;
        logic [2:0] f3;
        int         kind;
        logic [1:0] imm;
        logic       src, wb, ill, tk;
        logic [3:0] aop, st;
        op = in[6:0]; f3 = in[14:12];
        imm = 2'b00; src = 1'b0; wb = 1'b1; aop = 4'b0100;
        trace.delete();
        if (op == 7'b0110011 && (f3 inside {3'b000, 3'b100, 3'b110, 3'b111})) begin
            kind = K_R; aop = alu_of(f3, in[30]);
        end else if (op == 7'b0010011 && (f3 inside {3'b000, 3'b100, 3'b110, 3'b111})) begin
            kind = K_I; src = 1'b1; aop = alu_of(f3, 1'b0);
        end else if (op == 7'b0000011 && f3 == 3'b010) begin
            kind = K_LD; src = 1'b1; wb = 1'b0;
        end else if (op == 7'b0100011 && f3 == 3'b010) begin
            kind = K_ST; src = 1'b1; imm = 2'b01;
        end else if (op == 7'b1100011 && !(f3 inside {3'b010, 3'b011})) begin
            kind = K_BR; imm = 2'b10; aop = 4'b1100;
        end else if (op == 7'b1110011) begin
            kind = K_SYS;
        end else begin
            kind = K_ILL;
        end
        ill = m_illegal;
        for (int w = 0; w < waits; w++) add(1'b0, rb(), 4'($urandom), $urandom, idle(0, ill));
        add(1'b1, rb(), 4'($urandom), in, idle(0, ill));
        add(rb(), rb(), 4'($urandom), $urandom,
            (kind >= K_SYS) ? idle(0, ill) : mk(imm, 0, src, aop, 0, wb, 0, 0, 0, ill));
        if (kind == K_ILL) ill = 1'b1;
        case (kind)
            K_R, K_I: begin
                add(rb(), rb(), 4'($urandom), $urandom, mk(imm, 0, src, aop, 0, wb, 0, 0, 0, ill));
                add(rb(), rb(), 4'($urandom), $urandom, mk(imm, 1, src, aop, 0, wb, 0, 1, 0, ill));
            end
            K_BR: begin
                st = st_rand ? 4'($urandom) : st_fix;
                tk = br_taken(f3, st);
                add(rb(), rb(), st, $urandom, mk(imm, 0, src, aop, 0, wb, tk, 1, 0, ill));
            end
            K_LD, K_ST: begin
                add(rb(), rb(), 4'($urandom), $urandom, mk(imm, 0, src, aop, 0, wb, 0, 0, 0, ill));
                for (int s = 0; s < stalls; s++)
                    add(rb(), 1'b0, 4'($urandom), $urandom,
                        mk(imm, 0, src, aop, kind == K_ST, wb, 0, 0, 0, ill));
                add(rb(), 1'b1, 4'($urandom), $urandom,
                    mk(imm, 0, src, aop, kind == K_ST, wb, 0, kind == K_ST, 0, ill));
                if (kind == K_LD)
                    add(rb(), rb(), 4'($urandom), $urandom, mk(imm, 1, src, aop, 0, wb, 0, 1, 0, ill));
            end
            default: begin
                for (int h = 0; h < halt_tail; h++)
                    add(rb(), rb(), 4'($urandom), $urandom, idle(1, ill));
            end
        endcase
        m_illegal = ill;
    endfunction

    function automatic logic [31:0] gen_legal();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 4))
            0, 1: begin
                v[6:0] = ($urandom_range(0, 1) != 0) ? 7'b0110011 : 7'b0010011;
                case ($urandom_range(0, 3))
                    0:       v[14:12] = 3'b000;
                    1:       v[14:12] = 3'b100;
                    2:       v[14:12] = 3'b110;
                    default: v[14:12] = 3'b111;
                endcase
            end
            2: begin v[6:0] = 7'b0000011; v[14:12] = 3'b010; end
            3: begin v[6:0] = 7'b0100011; v[14:12] = 3'b010; end
            default: begin
                v[6:0] = 7'b1100011;
                case ($urandom_range(0, 5))
                    0:       v[14:12] = 3'b000;
                    1:       v[14:12] = 3'b001;
                    2:       v[14:12] = 3'b100;
                    3:       v[14:12] = 3'b101;
                    4:       v[14:12] = 3'b110;
                    default: v[14:12] = 3'b111;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic apply(input cyc_t c);
        bus.run       = c.run;
        bus.mem_ready = c.mem_ready;
        bus.Status    = c.status;
        bus.Instr     = c.instr;
    endtask

    task automatic pulse_reset();
        reset = 1'b1; bus.run = 1'b1; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.run = 1'b0;
        m_retired = '0; m_illegal = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.run = 1'b1; bus.mem_ready = 1'b1;
        bus.Status = 4'($urandom); bus.Instr = 32'h00450693;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (obs() !== idle(0, 0) || bus.retired !== '0) begin
            fails++;
            $display("FAIL reset: ctl=%b ret=%0d, expected ctl=%b ret=0", obs(), bus.retired, idle(0, 0));
        end
        @(posedge clk); #1;
        reset = 1'b0; m_retired = '0; m_illegal = 1'b0;
    endtask

    task automatic test_addi();
        build_trace(32'h00450693, 0, 0, 0, 1'b1, 4'h0);
        foreach (trace[k]) begin
            apply(trace[k]);
            @(negedge clk);
            tests++;
            if (obs() !== trace[k].exp || bus.retired !== m_retired) begin
                fails++;
                $display("FAIL addi cyc%0d: ctl=%b ret=%0d, expected ctl=%b ret=%0d",
                         k, obs(), bus.retired, trace[k].exp, m_retired);
            end
            if (trace[k].exp[2]) m_retired++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        build_trace(32'h0006A803, 0, 3, 0, 1'b1, 4'h0);
        foreach (trace[k]) begin
            apply(trace[k]);
            @(negedge clk);
            tests++;
            if (obs() !== trace[k].exp || bus.retired !== m_retired) begin
                fails++;
                $display("FAIL load cyc%0d: ctl=%b ret=%0d, expected ctl=%b ret=%0d",
                         k, obs(), bus.retired, trace[k].exp, m_retired);
            end
            if (trace[k].exp[2]) m_retired++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [31:0] bltu;
        logic [3:0]  st;
        bltu = {7'd0, 5'd11, 5'd14, 3'b110, 5'b01000, 7'b1100011};
        for (int pass = 0; pass < 2; pass++) begin
            st = (pass == 0) ? 4'b0000 : 4'b0010;
            build_trace(bltu, 0, 0, 0, 1'b0, st);
            foreach (trace[k]) begin
                apply(trace[k]);
                @(negedge clk);
                tests++;
                if (obs() !== trace[k].exp || bus.retired !== m_retired) begin
                    fails++;
                    $display("FAIL bltu st=%b cyc%0d: ctl=%b ret=%0d, expected ctl=%b ret=%0d",
                             st, k, obs(), bus.retired, trace[k].exp, m_retired);
                end
                if (trace[k].exp[2]) m_retired++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_store();
        build_trace(32'hFE322FA3, 1, 2, 0, 1'b1, 4'h0);
        foreach (trace[k]) begin
            apply(trace[k]);
            @(negedge clk);
            tests++;
            if (obs() !== trace[k].exp || bus.retired !== m_retired) begin
                fails++;
                $display("FAIL store cyc%0d: ctl=%b ret=%0d, expected ctl=%b ret=%0d",
                         k, obs(), bus.retired, trace[k].exp, m_retired);
            end
            if (trace[k].exp[2]) m_retired++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int n = 0; n < 40; n++) begin
            ins = gen_legal();
            build_trace(ins, $urandom_range(0, 2), $urandom_range(0, 3), 0, 1'b1, 4'h0);
            foreach (trace[k]) begin
                apply(trace[k]);
                @(negedge clk);
                tests++;
                if (obs() !== trace[k].exp || bus.retired !== m_retired) begin
                    fails++;
                    $display("FAIL rand #%0d instr=%h cyc%0d: ctl=%b ret=%0d, expected ctl=%b ret=%0d",
                             n, ins, k, obs(), bus.retired, trace[k].exp, m_retired);
                end
                if (trace[k].exp[2]) m_retired++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_halt();
        logic [31:0] list[3];
        list[0] = 32'h00000073;                                       // ecall: halts, legal
        list[1] = 32'hFFFFFFFF;                                       // unknown opcode
        list[2] = {17'd0, 3'b011, 5'd0, 7'b1100011};                  // branch funct3 011
        for (int t = 0; t < 3; t++) begin
            build_trace(list[t], 0, 0, 20, 1'b1, 4'h0);
            foreach (trace[k]) begin
                apply(trace[k]);
                @(negedge clk);
                tests++;
                if (obs() !== trace[k].exp || bus.retired !== m_retired) begin
                    fails++;
                    $display("FAIL halt instr=%h cyc%0d: ctl=%b ret=%0d, expected ctl=%b ret=%0d",
                             list[t], k, obs(), bus.retired, trace[k].exp, m_retired);
                end
                if (trace[k].exp[2]) m_retired++;
                @(posedge clk); #1;
            end
            pulse_reset();
            @(negedge clk);
            tests++;
            if (obs() !== idle(0, 0) || bus.retired !== '0) begin
                fails++;
                $display("FAIL halt_reset instr=%h: ctl=%b ret=%0d, expected ctl=%b ret=0",
                         list[t], obs(), bus.retired, idle(0, 0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mem();
        build_trace(32'hFE322FA3, 0, 10, 0, 1'b1, 4'h0);
        for (int k = 0; k < 6; k++) begin
            apply(trace[k]);
            @(negedge clk);
            tests++;
            if (obs() !== trace[k].exp || bus.retired !== m_retired) begin
                fails++;
                $display("FAIL rst_mem pre cyc%0d: ctl=%b ret=%0d, expected ctl=%b ret=%0d",
                         k, obs(), bus.retired, trace[k].exp, m_retired);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; bus.run = 1'b1; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        m_retired = '0; m_illegal = 1'b0;
        @(negedge clk);
        tests++;
        if (obs() !== idle(0, 0) || bus.retired !== m_retired) begin
            fails++;
            $display("FAIL rst_mem abort: ctl=%b ret=%0d, expected ctl=%b ret=0",
                     obs(), bus.retired, idle(0, 0));
        end
        @(posedge clk); #1;
        reset = 1'b0; bus.run = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.mem_ready = rb();
            @(negedge clk);
            tests++;
            if (obs() !== idle(0, 0) || bus.retired !== m_retired) begin
                fails++;
                $display("FAIL run_low cyc%0d: ctl=%b ret=%0d, expected ctl=%b ret=0",
                         c, obs(), bus.retired, idle(0, 0));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.run = 1'b0; bus.mem_ready = 1'b0; bus.Status = '0; bus.Instr = '0;
        m_retired = '0; m_illegal = 1'b0;
        test_reset();
        test_addi();
        test_load();
        test_branch();
        test_store();
        test_random();
        test_halt();
        test_reset_mem();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
